fp_addsub_pipe: RTL and testbench

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_addsub_pipe.sv | 164 ++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage pipelined floating-point add/subtract with flush-to-zero and round-to-nearest-even
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;
    localparam int SW = MAN_W + 5;
    localparam int FW = MAN_W + 1;
    localparam int XW = EXP_W + $clog2(MAN_W + 5) + 1;
    localparam logic [W-1:0]  QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
    typedef struct packed {
        logic             valid;
        logic             special;
        logic [W-1:0]     sres;
        logic [3:0]       sflags;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic             sub;
        logic [MW-1:0]    big;
        logic [MW-1:0]    sml;
    } s1_t;
    typedef struct packed {
        logic             valid;
        logic             special;
        logic [W-1:0]     sres;
        logic [3:0]       sflags;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SW-1:0]    sum;
    } s2_t;
    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    logic             out_valid_q;
    logic [W-1:0]     result_d, result_q;
    logic [3:0]       flags_d, flags_q;
    logic             adv;
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb, dexp;
    logic [MAN_W-1:0] ma, mb;
    logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, a_ge;
    logic [MW-1:0]    sml_x, sml_mask, sml_al;
    logic             carry, zero, inexact, up, unf, ovf;
    logic [XW-1:0]    lz, e_norm, e_r;
    logic [MW-1:0]    norm;
    logic [FW-1:0]    frac_r;
    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign sa = a[W-1];
    assign ea = a[W-2:MAN_W];
    assign ma = a[MAN_W-1:0];
    assign sb = b[W-1] ^ sub;
    assign eb = b[W-2:MAN_W];
    assign mb = b[MAN_W-1:0];
    assign a_nan  = (&ea) && (|ma);
    assign b_nan  = (&eb) && (|mb);
    assign a_snan = a_nan && !ma[MAN_W-1];
    assign b_snan = b_nan && !mb[MAN_W-1];
    assign a_inf  = (&ea) && !(|ma);
    assign b_inf  = (&eb) && !(|mb);
    assign a_zero = ea == '0;
    assign b_zero = eb == '0;
    assign a_ge   = {ea, ma} >= {eb, mb};
    assign dexp   = a_ge ? ea - eb : eb - ea;
    assign sml_x    = {1'b1, a_ge ? mb : ma, 3'b000};
    assign sml_mask = ~({MW{1'b1}} << dexp);
    assign sml_al   = 32'(dexp) >= MAN_W + 3 ? MW'(1) : (sml_x >> dexp) | MW'(|(sml_x & sml_mask));
    // Stage 1: unpack, resolve special operands, order by magnitude and align the smaller mantissa
    always_comb begin
        s1_d         = '0;
        s1_d.valid   = in_valid;
        s1_d.sign    = a_ge ? sa : sb;
        s1_d.exp     = a_ge ? ea : eb;
        s1_d.sub     = sa ^ sb;
        s1_d.big     = {1'b1, a_ge ? ma : mb, 3'b000};
        s1_d.sml     = sml_al;
        s1_d.special = 1'b1;
        if (a_nan || b_nan) begin
            s1_d.sres   = QNAN;
            s1_d.sflags = {a_snan || b_snan, 3'b000};
        end else if (a_inf && b_inf) begin
            s1_d.sres   = (sa == sb) ? {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : QNAN;
            s1_d.sflags = {sa != sb, 3'b000};
        end else if (a_zero && b_zero) begin
            s1_d.sres = {sa && sb, {(W-1){1'b0}}};
        end else if (a_inf || b_zero) begin
            s1_d.sres = a;
        end else if (b_inf || a_zero) begin
            s1_d.sres = {sb, eb, mb};
        end else begin
            s1_d.special = 1'b0;
        end
    end
    // Stage 2: magnitude add or subtract, one spare carry bit above the hidden bit
    always_comb begin
        s2_d.valid   = s1_q.valid;
        s2_d.special = s1_q.special;
        s2_d.sres    = s1_q.sres;
        s2_d.sflags  = s1_q.sflags;
        s2_d.sign    = s1_q.sign;
        s2_d.exp     = s1_q.exp;
        s2_d.sum     = s1_q.sub ? {1'b0, s1_q.big} - {1'b0, s1_q.sml} : {1'b0, s1_q.big} + {1'b0, s1_q.sml};
    end
    // Stage 3: leading-zero count of the sum below the carry bit; the highest set bit wins
    always_comb begin
        lz = '0;
        for (int i = 0; i < MW; i++) lz = s2_q.sum[i] ? XW'(MW - 1 - i) : lz;
    end
    assign carry   = s2_q.sum[SW-1];
    assign norm    = carry ? (s2_q.sum[SW-1:1] | MW'(s2_q.sum[0])) : s2_q.sum[MW-1:0] << lz;
    assign e_norm  = XW'(s2_q.exp) + (carry ? XW'(1) : -lz);
    assign zero    = !norm[MW-1];
    assign inexact = |norm[2:0];
    assign up      = norm[2] && (norm[1] || norm[0] || norm[3]);
    assign frac_r  = {1'b0, norm[MAN_W+2:3]} + FW'(up);
    assign e_r     = e_norm + XW'(frac_r[MAN_W]);
    assign unf     = e_norm[XW-1] || e_norm == '0;
    assign ovf     = e_r >= EMAX_X;
    // Stage 3: pack with flush-to-zero on underflow and infinity on overflow
    always_comb begin
        result_d = s2_q.special ? s2_q.sres :
                   zero         ? '0 :
                   unf          ? {s2_q.sign, {(W-1){1'b0}}} :
                   ovf          ? {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                                  {s2_q.sign, e_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
        flags_d  = s2_q.special ? s2_q.sflags :
                   zero         ? 4'b0000 :
                   unf          ? 4'b0011 :
                   ovf          ? 4'b0101 :
                                  {3'b000, inexact};
    end
    // All stages advance together unless the output is stalled; reset empties the pipe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (adv) begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= s2_q.valid;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: scoreboard bench with directed vectors for single and half precision instances
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid, in_ready, sub, out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] a, b, result;
    logic [3:0]  flags;
    logic        h_in_valid, h_in_ready, h_sub, h_out_valid;
    logic        h_out_ready = 1'b1;
    logic [15:0] h_a, h_b, h_result;
    logic [3:0]  h_flags;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [35:0] exp_q[$];
    logic [19:0] hexp_q[$];
    logic        rand_ready = 1'b0;
    logic        held_v = 1'b0;
    logic [35:0] held;
    logic [100:0] vecs [25] = '{
        {32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0},
        {32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0},
        {32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8},
        {32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5},
        {32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1},
        {32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'h0},
        {32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0},
        {32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000, 4'h0},
        {32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 4'h0},
        {32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0},
        {32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8},
        {32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'h0},
        {32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0},
        {32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0},
        {32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'h0},
        {32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'h0},
        {32'h12345678, 32'h00000000, 1'b0, 32'h12345678, 4'h0},
        {32'h00000000, 32'h40490FDB, 1'b1, 32'hC0490FDB, 4'h0},
        {32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0},
        {32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h3},
        {32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1},
        {32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 4'h1},
        {32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'h5},
        {32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8},
        {32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 4'h0}
    };

    fp_addsub_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .sub(h_sub), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .flags(h_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // scoreboard monitor for the single-precision instance, including hold-while-stalled checks
    always @(negedge clk) begin
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) check("hold_stable", {out_valid, result, flags}, {1'b1, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_output: got result %h with no outstanding operation", result);
                end else begin
                    logic [35:0] e;
                    e = exp_q.pop_front();
                    check("result", result, e[35:4]);
                    check("flags", flags, e[3:0]);
                end
            end
            held_v = out_valid && !out_ready;
            held = {result, flags};
        end
    end

    // scoreboard monitor for the half-precision instance
    always @(negedge clk) begin
        if (!reset && h_out_valid) begin
            if (hexp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL h_extra_output: got result %h with no outstanding operation", h_result);
            end else begin
                logic [19:0] e;
                e = hexp_q.pop_front();
                check("h_result", h_result, e[19:4]);
                check("h_flags", h_flags, e[3:0]);
            end
        end
    end

    task automatic send(logic [31:0] va, logic [31:0] vb, logic vs, logic [31:0] er, logic [3:0] ef);
        int  n = 0;
        logic acc;
        a = va;
        b = vb;
        sub = vs;
        in_valid = 1'b1;
        exp_q.push_back({er, ef});
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_vec(int i);
        send(vecs[i][100:69], vecs[i][68:37], vecs[i][36], vecs[i][35:4], vecs[i][3:0]);
    endtask

    task automatic hsend(logic [15:0] va, logic [15:0] vb, logic vs, logic [15:0] er, logic [3:0] ef);
        h_a = va;
        h_b = vb;
        h_sub = vs;
        h_in_valid = 1'b1;
        hexp_q.push_back({er, ef});
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || hexp_q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0 || hexp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size() + hexp_q.size());
        end
    endtask

    initial begin
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_flags", flags, 0);
        reset = 1'b0;
        #1;
        check("in_ready_after_reset", in_ready, 1);
        send_vec(0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("latency_out_valid", out_valid, k == 2);
        end
        drain();
        for (int i = 1; i <= 4; i++) send_vec(i);
        drain();
        hsend(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'h0);
        hsend(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'h0);
        hsend(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'h5);
        drain();
        for (int i = 5; i <= 7; i++) send_vec(i);
        check("inflight_out_valid", out_valid, 1);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_out_valid", out_valid, 0);
        check("async_reset_result", result, 0);
        check("async_reset_flags", flags, 0);
        exp_q.delete();
        hexp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("in_ready_after_release", in_ready, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_stale_output", out_valid, 0);
        end
        @(posedge clk);
        #1;
        rand_ready = 1'b1;
        for (int i = 0; i < 25; i++) send_vec(i);
        for (int i = 0; i < 8; i++) send_vec(i);
        repeat (10) @(posedge clk);
        rand_ready = 1'b0;
        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
